mem_scheduler: RTL and testbench
================================

MEM_SCHEDULER -- requirements
Module: mem_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of memory requesters (load/store buffers); fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT, default 15, WAIT cycles allowed without mem_done before abort.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester request level.
REQ-006 req_instr  input  43*N_REQ  requester i instruction at bits [43*i+42 : 43*i].
- Instruction format: [42:40] tag, [39] mem op, [38] store(1)/load(0), [35:32] dest reg, [31:16] store address, [15:0] store data or load address.
REQ-007 grant  output  N_REQ  one-hot, one-cycle pulse when a request is accepted.
REQ-008 key_mem  output  1  enable to memory unit.
REQ-009 mem_instr  output  43  instruction to memory unit.
REQ-010 mem_done  input  1  memory completion flag.
REQ-011 mem_solution  input  23  memory result {reg[22:19], tag[18:16], data[15:0]}.
REQ-012 cdb_valid  output  1  result valid on common data bus.
REQ-013 cdb_data  output  23  captured mem_solution.
REQ-014 cdb_src  output  2  index of requester that owns cdb_data.
REQ-015 cdb_ack  input  1  CDB accepted result.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 timeout_err  output  1  sticky abort flag.

Function
REQ-018 FSM states IDLE, WAIT, BCAST, RELEASE; all outputs registered.
REQ-019 Eligible requester: req[i]=1 and req_instr bit 39 = 1; req with bit 39 = 0 is ignored, never granted.
REQ-020 Round-robin: search starts at pointer p, ascending modulo N_REQ; p = granted index + 1 (mod N_REQ) after each grant.
REQ-021 IDLE, eligible requester present at edge k: after edge k grant[i]=1 for exactly one cycle, mem_instr = req_instr[i], cdb_src = i, key_mem=1, wait counter=0, state WAIT.
REQ-022 WAIT: key_mem and mem_instr held stable; each edge with mem_done=0 increments counter.
REQ-023 WAIT, mem_done=1: cdb_data <= mem_solution, cdb_valid <= 1, key_mem <= 0, state BCAST; with the memory unit's two-edge done latency, cdb_valid rises after edge k+3.
REQ-024 WAIT, counter reaches TIMEOUT with mem_done=0: timeout_err <= 1, key_mem <= 0, no broadcast, state RELEASE.
REQ-025 BCAST: cdb_valid, cdb_data, cdb_src held until sampled cdb_ack=1, then cdb_valid <= 0, state RELEASE; cdb_ack outside BCAST ignored.
REQ-026 RELEASE: key_mem=0; leave for IDLE on first edge with mem_done=0, guaranteeing the memory clears done before the next op.
REQ-027 A new grant occurs only from IDLE; minimum one IDLE cycle between operations.
REQ-028 Requester keeping req high after its grant is re-arbitrated in round-robin order, not privileged.
REQ-029 Simultaneous mem_done and counter = TIMEOUT on the same edge: completion wins, no error.
REQ-030 timeout_err cleared only by reset; operation continues normally after it sets.
REQ-031 busy=1 in WAIT, BCAST, RELEASE; 0 in IDLE.

Reset
REQ-032 reset asserted, any state: immediately state IDLE, p=0, counter=0, grant=0, key_mem=0, mem_instr=0, cdb_valid=0, cdb_data=0, cdb_src=0, busy=0, timeout_err=0.
REQ-033 Reset mid-operation drops the in-flight operation; no grant or broadcast issued for it after release.
REQ-034 First edge after reset release is evaluated as IDLE.

Verification
REQ-035 Single load: req=0001, instr tag=3, bit39=1, bit38=0, addr 0x0005; memory model returns data 0xBEEF -> grant=0001 one cycle, cdb_valid after edge k+3, cdb_data={reg,3'd3,16'hBEEF}, cdb_src=0.
REQ-036 All four requesting continuously, cdb_ack tied 1 -> grant order 0,1,2,3,0; no requester starved.
REQ-037 cdb_ack held low 5 cycles -> cdb_valid/cdb_data stable 5 cycles, no new grant; release after ack.
REQ-038 mem_done stuck 0 -> timeout_err=1 after TIMEOUT=15 WAIT cycles, key_mem=0, no cdb_valid; next request serviced normally.
REQ-039 mem_done held 1 for 3 extra cycles after BCAST -> FSM stays RELEASE, no grant until mem_done=0.
REQ-040 reset pulsed during WAIT -> all outputs 0 at once; req=0100 afterwards -> grant=0100, pointer starts from 0.

Source files
------------

// File: rtl/mem_scheduler.sv
// Round-robin memory request scheduler: grants one eligible requester at a time,
// drives the memory unit, and broadcasts the result on the CDB.
module mem_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [43*N_REQ-1:0]  i_req_instr,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_key_mem,
    output logic [42:0]          o_mem_instr,
    input  logic                 i_mem_done,
    input  logic [22:0]          i_mem_solution,
    output logic                 o_cdb_valid,
    output logic [22:0]          o_cdb_data,
    output logic [1:0]           o_cdb_src,
    input  logic                 i_cdb_ack,
    output logic                 o_busy,
    output logic                 o_timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BCAST,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [1:0]       w_sel;
    logic [1:0]       w_idx;

    // Search ascending from r_ptr; the 2-bit index wraps modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_elig[i] = i_req[i] & i_req_instr[43*i + 39];
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            o_grant       <= '0;
            o_key_mem     <= 1'b0;
            o_mem_instr   <= '0;
            o_cdb_valid   <= 1'b0;
            o_cdb_data    <= '0;
            o_cdb_src     <= '0;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        o_grant[w_sel] <= 1'b1;
                        o_mem_instr    <= i_req_instr[43*w_sel +: 43];
                        o_cdb_src      <= w_sel;
                        o_key_mem      <= 1'b1;
                        r_cnt          <= '0;
                        r_ptr          <= w_sel + 2'd1;
                        o_busy         <= 1'b1;
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over an expiring counter.
                    if (i_mem_done) begin
                        o_cdb_data  <= i_mem_solution;
                        o_cdb_valid <= 1'b1;
                        o_key_mem   <= 1'b0;
                        r_state     <= S_BCAST;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        o_timeout_err <= 1'b1;
                        o_key_mem     <= 1'b0;
                        r_state       <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BCAST: begin
                    if (i_cdb_ack) begin
                        o_cdb_valid <= 1'b0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!i_mem_done) begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scheduler.sv
// Scoreboard bench for mem_scheduler with a two-edge-latency memory model.
module tb_mem_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [171:0]  req_instr;
    logic [3:0]    grant;
    logic          key_mem;
    logic [42:0]   mem_instr;
    logic          mem_done;
    logic [22:0]   mem_solution;
    logic          cdb_valid;
    logic [22:0]   cdb_data;
    logic [1:0]    cdb_src;
    logic          ack;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    mem_scheduler #(.N_REQ(4), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_instr(req_instr),
        .o_grant(grant), .o_key_mem(key_mem), .o_mem_instr(mem_instr),
        .i_mem_done(mem_done), .i_mem_solution(mem_solution),
        .o_cdb_valid(cdb_valid), .o_cdb_data(cdb_data), .o_cdb_src(cdb_src),
        .i_cdb_ack(ack), .o_busy(busy), .o_timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: done two edges after key_mem is seen, cleared once key_mem drops
    // (optionally after hold_extra more edges). Returned data = address + 0xBEEA.
    logic mem_en = 1'b1;
    int   hold_extra = 0;
    int   hold_cnt;
    logic stage;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_done     <= 1'b0;
            mem_solution <= '0;
            stage        <= 1'b0;
            hold_cnt     <= 0;
        end else if (mem_done) begin
            if (!key_mem) begin
                if (hold_cnt == 0) mem_done <= 1'b0;
                else hold_cnt <= hold_cnt - 1;
            end
        end else if (key_mem && mem_en) begin
            if (!stage) stage <= 1'b1;
            else begin
                stage        <= 1'b0;
                mem_done     <= 1'b1;
                hold_cnt     <= hold_extra;
                mem_solution <= {mem_instr[35:32], mem_instr[42:40], mem_instr[15:0] + 16'hBEEA};
            end
        end else begin
            stage <= 1'b0;
        end
    end

    typedef struct { logic [3:0] g; logic [42:0] instr; } gexp_t;
    typedef struct { logic [22:0] d; logic [1:0] s; } bexp_t;
    gexp_t q_g[$];
    bexp_t q_b[$];
    gexp_t mg;
    bexp_t mb;
    logic  prev_v = 1'b0;

    function automatic logic [42:0] mk(input logic [2:0] tag, input logic mem,
                                       input logic [3:0] rg, input logic [15:0] lo);
        logic [42:0] v;
        v        = '0;
        v[42:40] = tag;
        v[39]    = mem;
        v[35:32] = rg;
        v[15:0]  = lo;
        return v;
    endfunction

    task automatic set_instr(input int i, input logic [42:0] v);
        req_instr[43*i +: 43] = v;
    endtask

    task automatic expect_op(input int i, input logic [42:0] ins, input bit bc);
        gexp_t e;
        bexp_t b;
        e.g     = 4'(1 << i);
        e.instr = ins;
        q_g.push_back(e);
        if (bc) begin
            b.d = {ins[35:32], ins[42:40], ins[15:0] + 16'hBEEA};
            b.s = 2'(i);
            q_b.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (grant != 4'b0) begin
                if (q_g.size() == 0) check("unexpected_grant", 64'(grant), 64'h0);
                else begin
                    mg = q_g.pop_front();
                    check("grant", 64'(grant), 64'(mg.g));
                    check("mem_instr", 64'(mem_instr), 64'(mg.instr));
                end
            end
            if (cdb_valid && !prev_v) begin
                if (q_b.size() == 0) check("unexpected_bcast", 64'(cdb_data), 64'h0);
                else begin
                    mb = q_b.pop_front();
                    check("cdb_data", 64'(cdb_data), 64'(mb.d));
                    check("cdb_src", 64'(cdb_src), 64'(mb.s));
                end
            end
            prev_v = cdb_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (grant != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_arrives", 64'(ok), 64'h1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!busy && !cdb_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("returns_idle", 64'(ok), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          bad;
        logic [22:0] held;

        rst = 1'b1; req = '0; req_instr = '0; ack = 1'b1;
        step(2);
        check("rst_ctrl", 64'({grant, key_mem, cdb_valid, busy, timeout_err}), 64'h0);
        check("rst_mem_instr", 64'(mem_instr), 64'h0);
        check("rst_cdb", 64'({cdb_data, cdb_src}), 64'h0);
        rst = 1'b0;

        // Single load: tag 3, reg 5, address 5 -> data 0xBEEF.
        set_instr(0, mk(3'd3, 1'b1, 4'h5, 16'h0005));
        expect_op(0, mk(3'd3, 1'b1, 4'h5, 16'h0005), 1'b1);
        req = 4'b0001;
        wait_grant();
        req = '0;
        check("t1_key_mem", 64'(key_mem), 64'h1);
        check("t1_busy", 64'(busy), 64'h1);
        step(1);
        check("t1_grant_one_cycle", 64'(grant), 64'h0);
        check("t1_key_mem_held", 64'(key_mem), 64'h1);
        step(1);
        check("t1_valid_k2", 64'(cdb_valid), 64'h0);
        step(1);
        check("t1_valid_k3", 64'(cdb_valid), 64'h1);
        check("t1_data", 64'(cdb_data), 64'({4'h5, 3'd3, 16'hBEEF}));
        wait_idle();

        // Non-memory instruction must never be granted.
        set_instr(1, mk(3'd1, 1'b0, 4'h1, 16'h0001));
        req = 4'b0010;
        step(8);
        check("nonmem_ignored", 64'(busy), 64'h0);
        req = '0;

        // Pointer back to 0, then all four request continuously.
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_instr(i, mk(3'(i + 1), 1'b1, 4'(i + 8), 16'(i * 16)));
        for (int r = 0; r < 5; r++) expect_op(r % 4, mk(3'((r % 4) + 1), 1'b1, 4'((r % 4) + 8), 16'((r % 4) * 16)), 1'b1);
        req = 4'b1111;
        for (int r = 0; r < 5; r++) wait_grant();
        req = '0;
        wait_idle();

        // Ack withheld for 5 cycles.
        ack = 1'b0;
        set_instr(2, mk(3'd6, 1'b1, 4'h2, 16'h0100));
        expect_op(2, mk(3'd6, 1'b1, 4'h2, 16'h0100), 1'b1);
        req = 4'b0100;
        wait_grant();
        req = '0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (cdb_valid) begin ok = 1'b1; break; end
        end
        check("t4_valid_arrives", 64'(ok), 64'h1);
        held = cdb_data;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (!cdb_valid || cdb_data !== held || grant != 4'b0 || !busy) bad++;
        end
        check("t4_held_cycles_bad", 64'(bad), 64'h0);
        ack = 1'b1;
        step(1);
        check("t4_valid_dropped", 64'(cdb_valid), 64'h0);
        wait_idle();

        // Memory never completes.
        mem_en = 1'b0;
        set_instr(3, mk(3'd7, 1'b1, 4'h3, 16'h0200));
        expect_op(3, mk(3'd7, 1'b1, 4'h3, 16'h0200), 1'b0);
        req = 4'b1000;
        wait_grant();
        req = '0;
        step(14);
        check("t5_no_early_err", 64'(timeout_err), 64'h0);
        check("t5_key_mem_waiting", 64'(key_mem), 64'h1);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (timeout_err) begin ok = 1'b1; break; end
        end
        check("t5_timeout_err", 64'(ok), 64'h1);
        check("t5_key_mem_off", 64'(key_mem), 64'h0);
        check("t5_no_valid", 64'(cdb_valid), 64'h0);
        wait_idle();
        mem_en = 1'b1;
        set_instr(0, mk(3'd2, 1'b1, 4'h4, 16'h0042));
        expect_op(0, mk(3'd2, 1'b1, 4'h4, 16'h0042), 1'b1);
        req = 4'b0001;
        wait_grant();
        req = '0;
        wait_idle();
        check("t5_err_sticky", 64'(timeout_err), 64'h1);

        // mem_done lingers 3 extra cycles; requester 0 waits behind requester 1.
        hold_extra = 3;
        set_instr(1, mk(3'd5, 1'b1, 4'h6, 16'h0300));
        set_instr(0, mk(3'd4, 1'b1, 4'h7, 16'h0400));
        expect_op(1, mk(3'd5, 1'b1, 4'h6, 16'h0300), 1'b1);
        expect_op(0, mk(3'd4, 1'b1, 4'h7, 16'h0400), 1'b1);
        req = 4'b0011;
        wait_grant();
        bad = 0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            if (grant != 4'b0 || !busy) bad++;
        end
        check("t6_held_in_release_bad", 64'(bad), 64'h0);
        step(1);
        check("t6_idle_after_done_low", 64'(busy), 64'h0);
        step(1);
        check("t6_next_grant", 64'(grant), 64'h1);
        req = '0;
        wait_idle();
        hold_extra = 0;

        // Reset during WAIT drops the operation and the pointer.
        mem_en = 1'b0;
        set_instr(2, mk(3'd1, 1'b1, 4'h9, 16'h0500));
        expect_op(2, mk(3'd1, 1'b1, 4'h9, 16'h0500), 1'b0);
        req = 4'b0100;
        wait_grant();
        req = '0;
        step(2);
        check("t7_in_wait", 64'(key_mem), 64'h1);
        rst = 1'b1;
        #1;
        check("t7_rst_ctrl", 64'({grant, key_mem, cdb_valid, busy, timeout_err}), 64'h0);
        check("t7_rst_mem_instr", 64'(mem_instr), 64'h0);
        check("t7_rst_cdb", 64'({cdb_data, cdb_src}), 64'h0);
        step(1);
        rst = 1'b0;
        mem_en = 1'b1;
        set_instr(3, mk(3'd3, 1'b1, 4'hA, 16'h0600));
        expect_op(2, mk(3'd1, 1'b1, 4'h9, 16'h0500), 1'b1);
        expect_op(3, mk(3'd3, 1'b1, 4'hA, 16'h0600), 1'b1);
        req = 4'b1100;
        wait_grant();
        wait_grant();
        req = '0;
        wait_idle();

        check("sb_grants_left", 64'(q_g.size()), 64'h0);
        check("sb_bcasts_left", 64'(q_b.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
